// File: rtl/sine_pkg.sv
// Shared constants, quadrant encoding and saturating negate for the sine ROM reader.
// The quarter-wave build is selected by defining SINE_QUARTER_WAVE_EN.
package sine_pkg;

  localparam int DEF_PHASE_W = 16;
  localparam int DEF_ADDR_W  = 6;
  localparam int DEF_DATA_W  = 32;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  // Two's-complement negate; the most negative value clamps to the most positive.
  function automatic logic [DEF_DATA_W-1:0] sat_negate(input logic [DEF_DATA_W-1:0] x);
    logic [DEF_DATA_W-1:0] most_neg;
    most_neg = {1'b1, {(DEF_DATA_W-1){1'b0}}};
    if (x == most_neg) return ~most_neg;
    return (~x) + 1'b1;
  endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator: adds tuning_word on every step, wrapping modulo 2^PHASE_W.
module phase_accumulator import sine_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic [PHASE_W-1:0] phase
);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (step) begin
      phase <= phase + tuning_word;
    end
  end

endmodule

// File: rtl/sine_rom_reader.sv
// Turns accepted ticks into ROM reads and presents one captured sample per tick, 3 cycles later.
// Define SINE_QUARTER_WAVE_EN for the quarter-wave table with mirrored addressing and sign.
module sine_rom_reader import sine_pkg::*; #(
  parameter int PHASE_W = DEF_PHASE_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               enable,
  input  logic [PHASE_W-1:0] tuning_word,
  output logic               rom_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  output logic [PHASE_W-1:0] phase
);

  logic              accept;
  logic [ADDR_W-1:0] index;
  logic              access_valid;
  logic [DATA_W-1:0] capture;

  assign accept = tick & enable;

  phase_accumulator #(.PHASE_W(PHASE_W)) u_phase (
    .clk         (clk),
    .rst         (rst),
    .step        (accept),
    .tuning_word (tuning_word),
    .phase       (phase)
  );

`ifdef SINE_QUARTER_WAVE_EN
  quad_t             quad;
  logic [ADDR_W-1:0] base;
  logic              negate;
  logic              negate_issue;
  logic              negate_access;

  assign quad   = quad_t'(phase[PHASE_W-1 -: 2]);
  assign base   = phase[PHASE_W-3 -: ADDR_W];
  // Odd quadrants walk the quarter table backwards; the lower half-wave is negated.
  assign index  = (quad == QUAD_1 || quad == QUAD_3) ? ~base : base;
  assign negate = (quad == QUAD_2 || quad == QUAD_3);

  always_ff @(posedge clk) begin
    if (rst) begin
      negate_issue  <= 1'b0;
      negate_access <= 1'b0;
    end else begin
      if (accept) negate_issue <= negate;
      negate_access <= negate_issue;
    end
  end

  assign capture = negate_access ? DATA_W'(sat_negate(DEF_DATA_W'(rom_data))) : rom_data;
`else
  assign index   = phase[PHASE_W-1 -: ADDR_W];
  assign capture = rom_data;
`endif

  // rom_en doubles as the issue-stage valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en       <= 1'b0;
      rom_addr     <= '0;
      access_valid <= 1'b0;
      sample_valid <= 1'b0;
      sample       <= '0;
    end else begin
      rom_en       <= accept;
      access_valid <= rom_en;
      sample_valid <= access_valid;
      if (accept)       rom_addr <= index;
      if (access_valid) sample   <= capture;
    end
  end

endmodule

// File: tb/tb_sine_rom_reader.sv
// Randomised and directed bench for sine_rom_reader against a queue-based latency model.
// Honours SINE_QUARTER_WAVE_EN so the same bench covers either table build.
module tb_sine_rom_reader;

  localparam int PHASE_W = 16;
  localparam int ADDR_W  = 6;
  localparam int DATA_W  = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic               enable;
  logic [PHASE_W-1:0] tuning_word;
  logic               rom_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic [DATA_W-1:0]  rom_data = '0;
  logic [DATA_W-1:0]  sample;
  logic               sample_valid;
  logic [PHASE_W-1:0] phase;

  sine_rom_reader #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .enable       (enable),
    .tuning_word  (tuning_word),
    .rom_en       (rom_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sample       (sample),
    .sample_valid (sample_valid),
    .phase        (phase)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] rom [64];

  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
  end

  typedef struct {
    int                due;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t               pending[$];
  logic [PHASE_W-1:0] m_phase;
  logic               m_en;
  logic [ADDR_W-1:0]  m_addr;
  logic [DATA_W-1:0]  m_sample;
  int                 cyc = 0;
  int                 checks = 0;
  int                 errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int model_index(input logic [PHASE_W-1:0] ph);
    int p;
    p = int'(ph);
`ifdef SINE_QUARTER_WAVE_EN
    if (((p / 16384) % 2) == 1) return 63 - ((p / 256) % 64);
    return (p / 256) % 64;
`else
    return p / 1024;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] model_sample(input logic [PHASE_W-1:0] ph);
    logic [DATA_W-1:0] w;
    w = rom[model_index(ph)];
`ifdef SINE_QUARTER_WAVE_EN
    if (int'(ph) >= 32768) begin
      if (w == 32'h8000_0000) return 32'h7FFF_FFFF;
      return 32'd0 - w;
    end
`endif
    return w;
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, check at the falling edge.
  task automatic cycle(input logic t, input logic e, input logic r, input logic [PHASE_W-1:0] tw);
    logic exp_v;
    tick = t; enable = e; rst = r; tuning_word = tw;
    @(posedge clk);
    cyc++;
    if (r) begin
      m_phase = '0; m_en = 1'b0; m_addr = '0; m_sample = '0;
      pending.delete();
    end else if (t && e) begin
      m_en   = 1'b1;
      m_addr = ADDR_W'(model_index(m_phase));
      pending.push_back('{due: cyc + 2, val: model_sample(m_phase)});
      m_phase = m_phase + tw;
    end else begin
      m_en = 1'b0;
    end
    exp_v = 1'b0;
    if (pending.size() > 0 && pending[0].due == cyc) begin
      exp_v    = 1'b1;
      m_sample = pending[0].val;
      void'(pending.pop_front());
    end
    @(negedge clk);
    check("phase", 64'(phase), 64'(m_phase));
    check("rom_en", 64'(rom_en), 64'(m_en));
    check("rom_addr", 64'(rom_addr), 64'(m_addr));
    check("sample_valid", 64'(sample_valid), 64'(exp_v));
    check("sample", 64'(sample), 64'(m_sample));
  endtask

  task automatic idle(input int n, input logic [PHASE_W-1:0] tw);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, tw);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[0] = 32'h8000_0000;
    rst = 1'b1; tick = 1'b1; enable = 1'b1; tuning_word = 16'h0400;

    // Reset held with tick high, then first tick right as reset drops.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 16'h0400);
    cycle(1'b1, 1'b1, 1'b0, 16'h0400);
    idle(4, 16'h0400);

    // Full address sweep, one tick every 8 cycles.
    cycle(1'b0, 1'b1, 1'b1, 16'h0400);
    for (int k = 0; k < 65; k++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0400);
      idle(7, 16'h0400);
    end

    // Back-to-back ticks.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 16'h0400);
    idle(5, 16'h0400);

    // Wrap from 0xFC00 and frozen phase with enable low.
    cycle(1'b0, 1'b1, 1'b1, 16'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'hFC00);
    idle(3, 16'h0400);
    cycle(1'b1, 1'b1, 1'b0, 16'h0400);
    idle(3, 16'h0400);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 16'h1234);
    // Enable drops with reads in flight.
    cycle(1'b1, 1'b1, 1'b0, 16'h0C00);
    cycle(1'b1, 1'b1, 1'b0, 16'h0C00);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0C00);

    // Zero tuning word re-reads one address.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0000);
      idle(1, 16'h0000);
    end
    idle(3, 16'h0000);

    // Reset one cycle after a tick: no strobe, sample cleared.
    cycle(1'b1, 1'b1, 1'b0, 16'h0400);
    cycle(1'b0, 1'b1, 1'b1, 16'h0400);
    idle(4, 16'h0400);

    // Quadrant corners: phases 0x0000, 0x4000, 0x8000, 0xC000.
    cycle(1'b0, 1'b1, 1'b1, 16'h4000);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h4000);
      idle(3, 16'h4000);
    end

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 60) == 0), 16'($urandom));
    end
    idle(4, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
